// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter sharing four register-file write ports among NUM_REQ requesters
// Optional feature macro: REGFILE_WARB_ADDR_CONFLICT_EN (suppress same-address grants within one cycle).
module regfile_write_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 64,
    parameter int MASK_W  = 8,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*MASK_W-1:0] req_mask,
    output logic [3:0]                w_en,
    output logic [4*ADDR_W-1:0]       w_addr,
    output logic [4*DATA_W-1:0]       w_data,
    output logic [4*MASK_W-1:0]       w_mask,
    output logic [PTR_W-1:0]          rr_ptr_o
);

    localparam int NPORT = 4;

    logic [ADDR_W-1:0] in_addr [NUM_REQ];
    logic [DATA_W-1:0] in_data [NUM_REQ];
    logic [MASK_W-1:0] in_mask [NUM_REQ];

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]        w_en_q, w_en_d;
    logic [ADDR_W-1:0] w_addr_q [NPORT];
    logic [ADDR_W-1:0] w_addr_d [NPORT];
    logic [DATA_W-1:0] w_data_q [NPORT];
    logic [DATA_W-1:0] w_data_d [NPORT];
    logic [MASK_W-1:0] w_mask_q [NPORT];
    logic [MASK_W-1:0] w_mask_d [NPORT];

    logic [NUM_REQ-1:0] grant;
    logic [2:0]         scan_cnt;
    logic [PTR_W:0]     scan_sum;
    logic [PTR_W-1:0]   scan_idx;
    logic               scan_elig;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign in_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign in_data[i] = req_data[i*DATA_W +: DATA_W];
        assign in_mask[i] = req_mask[i*MASK_W +: MASK_W];
    end

    // Scan from rr_ptr with wrap; the k-th winner lands on port k, unused ports hold.
    always_comb begin
        grant     = '0;
        w_en_d    = '0;
        rr_ptr_d  = rr_ptr_q;
        scan_cnt  = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        scan_elig = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            w_addr_d[k] = w_addr_q[k];
            w_data_d[k] = w_data_q[k];
            w_mask_d[k] = w_mask_q[k];
        end
        for (int o = 0; o < NUM_REQ; o++) begin
            scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(o);
            if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
            end
            scan_idx  = scan_sum[PTR_W-1:0];
            scan_elig = req_valid[scan_idx] && (scan_cnt < 3'd4);
`ifdef REGFILE_WARB_ADDR_CONFLICT_EN
            // Ports below scan_cnt already carry this cycle's winners.
            for (int j = 0; j < NPORT; j++) begin
                if ((3'(j) < scan_cnt) && (w_addr_d[j] == in_addr[scan_idx])) begin
                    scan_elig = 1'b0;
                end
            end
`endif
            if (scan_elig) begin
                grant[scan_idx]             = 1'b1;
                w_en_d[scan_cnt[1:0]]       = 1'b1;
                w_addr_d[scan_cnt[1:0]]     = in_addr[scan_idx];
                w_data_d[scan_cnt[1:0]]     = in_data[scan_idx];
                w_mask_d[scan_cnt[1:0]]     = in_mask[scan_idx];
                scan_cnt                    = scan_cnt + 3'd1;
                rr_ptr_d = (scan_idx == PTR_W'(NUM_REQ-1)) ? '0 : scan_idx + PTR_W'(1);
            end
        end
    end

    assign req_ready = grant & {NUM_REQ{reset_n}};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            w_en_q   <= '0;
            for (int k = 0; k < NPORT; k++) begin
                w_addr_q[k] <= '0;
                w_data_q[k] <= '0;
                w_mask_q[k] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            w_en_q   <= w_en_d;
            for (int k = 0; k < NPORT; k++) begin
                w_addr_q[k] <= w_addr_d[k];
                w_data_q[k] <= w_data_d[k];
                w_mask_q[k] <= w_mask_d[k];
            end
        end
    end

    for (genvar k = 0; k < NPORT; k++) begin : g_pack
        assign w_addr[k*ADDR_W +: ADDR_W] = w_addr_q[k];
        assign w_data[k*DATA_W +: DATA_W] = w_data_q[k];
        assign w_mask[k*MASK_W +: MASK_W] = w_mask_q[k];
    end

    assign w_en     = w_en_q;
    assign rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed scoreboard bench for regfile_write_arbiter (NUM_REQ=8)
module tb_regfile_write_arbiter;

    logic         clock;
    logic         reset_n;
    logic [7:0]   req_valid;
    logic [7:0]   req_ready;
    logic [55:0]  req_addr;
    logic [511:0] req_data;
    logic [63:0]  req_mask;
    logic [3:0]   w_en;
    logic [27:0]  w_addr;
    logic [255:0] w_data;
    logic [31:0]  w_mask;
    logic [2:0]   rr_ptr_o;

    logic [6:0]  a  [8];
    logic [63:0] d  [8];
    logic [7:0]  m  [8];
    logic [6:0]  ea [4];
    logic [63:0] ed [4];
    logic [7:0]  em [4];

    typedef struct {
        logic [3:0]   en;
        logic [27:0]  addr;
        logic [255:0] data;
        logic [31:0]  mask;
        logic [2:0]   ptr;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fails  = 0;
    int step_no  = 0;

    regfile_write_arbiter #(.NUM_REQ(8), .ADDR_W(7), .DATA_W(64), .MASK_W(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
        .rr_ptr_o(rr_ptr_o)
    );

    for (genvar i = 0; i < 8; i++) begin : g_drv
        assign req_addr[i*7 +: 7]  = a[i];
        assign req_data[i*64 +: 64] = d[i];
        assign req_mask[i*8 +: 8]  = m[i];
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; g0..g3 are the expected winners in port order (-1 = unused).
    task automatic step(input logic [7:0] v, input int g0, input int g1, input int g2,
                        input int g3, input logic [2:0] nptr);
        exp_t       e;
        logic [7:0] er;
        int         g [4];
        step_no++;
        g = '{g0, g1, g2, g3};
        for (int i = 0; i < 8; i++) d[i] = {$urandom(), $urandom()};
        req_valid = v;
        #1;
        er   = '0;
        e.en = '0;
        for (int k = 0; k < 4; k++) begin
            if (g[k] >= 0) begin
                er[g[k]] = 1'b1;
                e.en[k]  = 1'b1;
                ea[k]    = a[g[k]];
                ed[k]    = d[g[k]];
                em[k]    = m[g[k]];
            end
            e.addr[k*7 +: 7]   = ea[k];
            e.data[k*64 +: 64] = ed[k];
            e.mask[k*8 +: 8]   = em[k];
        end
        e.ptr = nptr;
        check($sformatf("s%0d_ready", step_no), 256'(req_ready), 256'(er));
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check($sformatf("s%0d_w_en", step_no), 256'(w_en), 256'(e.en));
        check($sformatf("s%0d_w_addr", step_no), 256'(w_addr), 256'(e.addr));
        check($sformatf("s%0d_w_data", step_no), w_data, e.data);
        check($sformatf("s%0d_w_mask", step_no), 256'(w_mask), 256'(e.mask));
        check($sformatf("s%0d_rr_ptr", step_no), 256'(rr_ptr_o), 256'(e.ptr));
        @(negedge clock);
    endtask

    task automatic set_addrs();
        for (int i = 0; i < 8; i++) begin
            a[i] = 7'(8'h40 + i);
            m[i] = 8'hF0 | 8'(i);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 8'hFF;
        set_addrs();
        for (int i = 0; i < 8; i++) d[i] = {$urandom(), $urandom()};
        for (int k = 0; k < 4; k++) begin
            ea[k] = '0;
            ed[k] = '0;
            em[k] = '0;
        end
        repeat (3) @(negedge clock);
        check("rst_ready", 256'(req_ready), 256'(0));
        check("rst_w_en", 256'(w_en), 256'(0));
        check("rst_rr_ptr", 256'(rr_ptr_o), 256'(0));
        check("rst_w_addr", 256'(w_addr), 256'(0));
        check("rst_w_data", w_data, 256'(0));
        check("rst_w_mask", 256'(w_mask), 256'(0));
        reset_n = 1'b1;

        // All requesters valid: alternating halves, pointer 0,4,0,4,...
        step(8'hFF, 0, 1, 2, 3, 3'd4);
        step(8'hFF, 4, 5, 6, 7, 3'd0);
        step(8'hFF, 0, 1, 2, 3, 3'd4);
        step(8'hFF, 4, 5, 6, 7, 3'd0);
        step(8'hFF, 0, 1, 2, 3, 3'd4);
        step(8'h30, 4, 5, -1, -1, 3'd6);
        // Wrap from pointer 6: requester 7 first, then 1
        step(8'h82, 7, 1, -1, -1, 3'd2);
        m[2] = 8'h00;
        step(8'h04, 2, -1, -1, -1, 3'd3);
        step(8'h00, -1, -1, -1, -1, 3'd3);
        step(8'hF8, 3, 4, 5, 6, 3'd7);
        step(8'h80, 7, -1, -1, -1, 3'd0);

        // Same address on requesters 0 and 2 with pointer at 0
        a[0] = 7'h15;
        a[2] = 7'h15;
        a[1] = 7'h21;
        a[3] = 7'h33;
`ifdef REGFILE_WARB_ADDR_CONFLICT_EN
        step(8'h0F, 0, 1, 3, -1, 3'd4);
`else
        step(8'h0F, 0, 1, 2, 3, 3'd4);
`endif
        step(8'h04, 2, -1, -1, -1, 3'd3);

        // Reset while a 4-wide write is on the ports
        set_addrs();
        step(8'hFF, 3, 4, 5, 6, 3'd7);
        req_valid = 8'h00;
        reset_n   = 1'b0;
        #1;
        check("midrst_w_en", 256'(w_en), 256'(0));
        check("midrst_rr_ptr", 256'(rr_ptr_o), 256'(0));
        check("midrst_w_addr", 256'(w_addr), 256'(0));
        check("midrst_ready", 256'(req_ready), 256'(0));
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("postrst_w_en", 256'(w_en), 256'(0));
        for (int k = 0; k < 4; k++) begin
            ea[k] = '0;
            ed[k] = '0;
            em[k] = '0;
        end
        @(negedge clock);
        step(8'hFF, 0, 1, 2, 3, 3'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
